// File: rtl/snd_regctrl_mc.sv
// Multi-slot register controller for the sound IP: bus/SPI register file, slot pointer, volume/filter.
// Define SND_VOL_RAMP_EN to route volume through a rate-limited ramp instead of the raw targets.
module snd_regctrl_mc #(
  parameter int NSLOT    = 4,
  parameter int RAMP_DIV = 1024,
  localparam int SW      = $clog2(NSLOT)
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic [15:0]   WRADDR,
  input  logic [3:0]    BYTEEN,
  input  logic          WREN,
  input  logic [31:0]   WDATA,
  input  logic [15:0]   RDADDR,
  input  logic          RDEN,
  output logic [31:0]   RDATA,
  input  logic [7:0]    SPI_GET_DATA,
  input  logic          SPI_DATA_VALID,
  output logic [1:0]    COMMAND,
  output logic          LOOP,
  output logic [28:0]   SNDADDR,
  output logic [28:0]   DATASIZE,
  output logic [SW-1:0] SLOT_SEL,
  output logic          SLOT_CHG,
  output logic [7:0]    VOLUME_L,
  output logic [7:0]    VOLUME_R,
  output logic [3:0]    FIL_PARAM_L,
  output logic [3:0]    FIL_PARAM_R
);

  logic          wr_hit_s, rd_hit_s;
  logic [9:0]    widx_s, ridx_s;
  logic [31:0]   rd_val_s;
  logic [7:0]    vol_l_s, vol_r_s;
  logic          slot_load_s;

  logic [1:0]    cmd_q, cmd_d;
  logic          loop_q, loop_d;
  logic [7:0]    tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [3:0]    fil_l_q, fil_l_d, fil_r_q, fil_r_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          slot_chg_q;
  logic [31:0]   spistat_q, spistat_d;
  logic [31:0]   rdata_q;
  logic [28:0]   addr_q [NSLOT];
  logic [28:0]   addr_d [NSLOT];
  logic [28:0]   size_q [NSLOT];
  logic [28:0]   size_d [NSLOT];

  logic unused_s;
  assign unused_s = ^{WRADDR[1:0], RDADDR[1:0], WDATA[31:29]};

  assign wr_hit_s = WREN && (WRADDR[15:12] == 4'h3);
  assign rd_hit_s = RDEN && (RDADDR[15:12] == 4'h3);
  assign widx_s   = WRADDR[11:2];
  assign ridx_s   = RDADDR[11:2];

  // Byte-enabled update of a 29-bit slot field; the top byte only carries bits 28:24.
  function automatic logic [28:0] be_merge(input logic [28:0] cur, input logic [31:0] wd,
                                           input logic [3:0] be);
    be_merge = cur;
    if (be[0]) be_merge[7:0]   = wd[7:0];
    if (be[1]) be_merge[15:8]  = wd[15:8];
    if (be[2]) be_merge[23:16] = wd[23:16];
    if (be[3]) be_merge[28:24] = wd[28:24];
  endfunction

  // SPI decode first, bus write second, so the bus overrides any field both touch.
  always_comb begin
    cmd_d       = cmd_q;
    loop_d      = loop_q;
    tgt_l_d     = tgt_l_q;
    tgt_r_d     = tgt_r_q;
    fil_l_d     = fil_l_q;
    fil_r_d     = fil_r_q;
    slot_d      = slot_q;
    slot_load_s = 1'b0;
    spistat_d   = spistat_q;
    addr_d      = addr_q;
    size_d      = size_q;
    if (SPI_DATA_VALID) begin
      spistat_d = {spistat_q[23:0], SPI_GET_DATA};
      case (SPI_GET_DATA[7:5])
        3'b001: begin
          slot_load_s = 1'b1;
          if (!SPI_GET_DATA[4]) slot_d = SPI_GET_DATA[SW-1:0];
          else if (!SPI_GET_DATA[0]) slot_d = slot_q + SW'(1);
          else slot_d = slot_q - SW'(1);
        end
        3'b010: begin
          if (SPI_GET_DATA[4]) fil_r_d = SPI_GET_DATA[3:0];
          else fil_l_d = SPI_GET_DATA[3:0];
        end
        3'b011:         cmd_d   = SPI_GET_DATA[1:0];
        3'b100, 3'b101: tgt_r_d = {SPI_GET_DATA[5:0], 2'b00};
        3'b110, 3'b111: tgt_l_d = {SPI_GET_DATA[5:0], 2'b00};
        default: begin
        end
      endcase
    end else begin
      spistat_d = spistat_q;
    end
    if (wr_hit_s) begin
      case (widx_s)
        10'h000: if (BYTEEN[0]) begin
          cmd_d  = WDATA[1:0];
          loop_d = WDATA[2];
        end
        10'h001: begin
          if (BYTEEN[1]) tgt_l_d = WDATA[15:8];
          if (BYTEEN[0]) tgt_r_d = WDATA[7:0];
        end
        10'h002: if (BYTEEN[0]) begin
          fil_l_d = WDATA[3:0];
          fil_r_d = WDATA[7:4];
        end
        10'h003: if (BYTEEN[0]) begin
          slot_d      = WDATA[SW-1:0];
          slot_load_s = 1'b1;
        end
        default: begin
          for (int k = 0; k < NSLOT; k++) begin
            if (widx_s == 10'(16 + 2 * k)) addr_d[k] = be_merge(addr_q[k], WDATA, BYTEEN);
            if (widx_s == 10'(17 + 2 * k)) size_d[k] = be_merge(size_q[k], WDATA, BYTEEN);
          end
        end
      endcase
    end else begin
      cmd_d = cmd_d;
    end
  end

  // Read mux; unmapped indices and unused bits return zero.
  always_comb begin
    rd_val_s = 32'h0;
    case (ridx_s)
      10'h000: rd_val_s = {29'h0, loop_q, cmd_q};
      10'h001: rd_val_s = {16'h0, tgt_l_q, tgt_r_q};
      10'h002: rd_val_s = {24'h0, fil_r_q, fil_l_q};
      10'h003: rd_val_s = {{(32 - SW){1'b0}}, slot_q};
      10'h004: rd_val_s = spistat_q;
      10'h005: rd_val_s = {16'h0, vol_l_s, vol_r_s};
      default: begin
        for (int k = 0; k < NSLOT; k++) begin
          if (ridx_s == 10'(16 + 2 * k)) rd_val_s = {3'b000, addr_q[k]};
          if (ridx_s == 10'(17 + 2 * k)) rd_val_s = {3'b000, size_q[k]};
        end
      end
    endcase
  end

  // Register file state, SLOT_CHG pulse and read-data capture.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      cmd_q      <= 2'b00;
      loop_q     <= 1'b0;
      tgt_l_q    <= 8'h00;
      tgt_r_q    <= 8'h00;
      fil_l_q    <= 4'h0;
      fil_r_q    <= 4'h0;
      slot_q     <= '0;
      slot_chg_q <= 1'b0;
      spistat_q  <= 32'h0;
      rdata_q    <= 32'h0;
      for (int k = 0; k < NSLOT; k++) begin
        addr_q[k] <= 29'h0;
        size_q[k] <= 29'h0;
      end
    end else begin
      cmd_q      <= cmd_d;
      loop_q     <= loop_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      fil_l_q    <= fil_l_d;
      fil_r_q    <= fil_r_d;
      slot_q     <= slot_d;
      slot_chg_q <= slot_load_s;
      spistat_q  <= spistat_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      if (rd_hit_s) rdata_q <= rd_val_s;
    end
  end

`ifdef SND_VOL_RAMP_EN
  localparam int DW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  logic [DW-1:0] div_q;
  logic [7:0]    vol_l_q, vol_r_q;

  function automatic logic [7:0] vol_step(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) vol_step = cur + 8'd1;
    else if (cur > tgt) vol_step = cur - 8'd1;
    else vol_step = cur;
  endfunction

  // Free-running divider; each terminal count moves both channels one step toward target.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      div_q   <= '0;
      vol_l_q <= 8'h00;
      vol_r_q <= 8'h00;
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      vol_l_q <= vol_step(vol_l_q, tgt_l_q);
      vol_r_q <= vol_step(vol_r_q, tgt_r_q);
    end else begin
      div_q   <= div_q + DW'(1);
    end
  end

  assign vol_l_s = vol_l_q;
  assign vol_r_s = vol_r_q;
`else
  assign vol_l_s = tgt_l_q;
  assign vol_r_s = tgt_r_q;
`endif

  assign RDATA       = rdata_q;
  assign COMMAND     = cmd_q;
  assign LOOP        = loop_q;
  assign SNDADDR     = addr_q[slot_q];
  assign DATASIZE    = size_q[slot_q];
  assign SLOT_SEL    = slot_q;
  assign SLOT_CHG    = slot_chg_q;
  assign VOLUME_L    = vol_l_s;
  assign VOLUME_R    = vol_r_s;
  assign FIL_PARAM_L = fil_l_q;
  assign FIL_PARAM_R = fil_r_q;

endmodule

// File: tb/tb_snd_regctrl_mc.sv
// Self-checking bench for snd_regctrl_mc (NSLOT=4, RAMP_DIV=4); read results go through a scoreboard queue.
// Ramp scenarios are compiled in when SND_VOL_RAMP_EN is defined, direct-volume checks otherwise.
module tb_snd_regctrl_mc;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic [15:0] WRADDR = 16'h0;
  logic [3:0]  BYTEEN = 4'h0;
  logic        WREN = 1'b0;
  logic [31:0] WDATA = 32'h0;
  logic [15:0] RDADDR = 16'h0;
  logic        RDEN = 1'b0;
  logic [31:0] RDATA;
  logic [7:0]  SPI_GET_DATA = 8'h0;
  logic        SPI_DATA_VALID = 1'b0;
  logic [1:0]  COMMAND;
  logic        LOOP;
  logic [28:0] SNDADDR, DATASIZE;
  logic [1:0]  SLOT_SEL;
  logic        SLOT_CHG;
  logic [7:0]  VOLUME_L, VOLUME_R;
  logic [3:0]  FIL_PARAM_L, FIL_PARAM_R;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] spi_hist = 32'h0;
  logic [31:0] last_rd = 32'h0;

  snd_regctrl_mc #(.NSLOT(4), .RAMP_DIV(4)) dut (
    .ACLK(ACLK), .ARST(ARST), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA), .SPI_GET_DATA(SPI_GET_DATA),
    .SPI_DATA_VALID(SPI_DATA_VALID), .COMMAND(COMMAND), .LOOP(LOOP), .SNDADDR(SNDADDR),
    .DATASIZE(DATASIZE), .SLOT_SEL(SLOT_SEL), .SLOT_CHG(SLOT_CHG), .VOLUME_L(VOLUME_L),
    .VOLUME_R(VOLUME_R), .FIL_PARAM_L(FIL_PARAM_L), .FIL_PARAM_R(FIL_PARAM_R)
  );

  always #5 ACLK = ~ACLK;

  // Scoreboard consumer: every cycle with RDEN high retires one expected RDATA value.
  always @(posedge ACLK) begin
    if (RDEN === 1'b1) begin
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL read_sb: got %08h with no expected value queued", RDATA);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (RDATA !== e) begin n_err++; $display("FAIL read: got %08h want %08h", RDATA, e); end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARST = 1'b1; tick(); tick(); ARST = 1'b0;
    spi_hist = 32'h0; last_rd = 32'h0;
  endtask

  task automatic bus_write(input logic [9:0] idx, input logic [3:0] be, input logic [31:0] d);
    WRADDR = {4'h3, idx, 2'b00}; BYTEEN = be; WDATA = d; WREN = 1'b1;
    tick(); WREN = 1'b0;
  endtask

  task automatic spi(input logic [7:0] b);
    SPI_GET_DATA = b; SPI_DATA_VALID = 1'b1; spi_hist = {spi_hist[23:0], b};
    tick(); SPI_DATA_VALID = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] idx, input logic [31:0] e);
    RDADDR = {4'h3, idx, 2'b00}; RDEN = 1'b1; exp_q.push_back(e); last_rd = e;
    tick(); RDEN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({COMMAND, LOOP, SNDADDR, DATASIZE, SLOT_SEL, SLOT_CHG, VOLUME_L, VOLUME_R,
         FIL_PARAM_L, FIL_PARAM_R, RDATA} !== 120'h0) begin
      n_err++; $display("FAIL reset_outputs: got cmd=%0d loop=%0d addr=%h size=%h slot=%0d chg=%0d vol=%h/%h rdata=%h want all 0",
                        COMMAND, LOOP, SNDADDR, DATASIZE, SLOT_SEL, SLOT_CHG, VOLUME_L, VOLUME_R, RDATA);
    end
    bus_read(10'h004, 32'h0);
  endtask

  task automatic test_slot_select();
    do_reset();
    bus_write(10'h014, 4'hF, 32'h1234_5678);
    bus_write(10'h015, 4'hF, 32'h0000_1000);
    spi(8'h63);
    spi(8'h22);
    n_cmp++; if (SLOT_SEL !== 2'd2) begin n_err++; $display("FAIL slot_sel: got %0d want 2", SLOT_SEL); end
    n_cmp++; if (SLOT_CHG !== 1'b1) begin n_err++; $display("FAIL slot_chg_pulse: got %0d want 1", SLOT_CHG); end
    n_cmp++; if (SNDADDR !== 29'h1234_5678) begin n_err++; $display("FAIL sndaddr: got %h want 12345678", SNDADDR); end
    n_cmp++; if (DATASIZE !== 29'h1000) begin n_err++; $display("FAIL datasize: got %h want 1000", DATASIZE); end
    n_cmp++; if (COMMAND !== 2'd3) begin n_err++; $display("FAIL cmd_kept: got %0d want 3", COMMAND); end
    tick();
    n_cmp++; if (SLOT_CHG !== 1'b0) begin n_err++; $display("FAIL slot_chg_once: got %0d want 0", SLOT_CHG); end
    bus_read(10'h014, 32'h1234_5678);
    bus_write(10'h010, 4'hF, 32'hFFFF_FFFF);
    bus_read(10'h010, 32'h1FFF_FFFF);
    bus_write(10'h010, 4'b0001, 32'h0);
    bus_read(10'h010, 32'h1FFF_FF00);
    bus_write(10'h017, 4'b1000, 32'hE500_0000);
    bus_read(10'h017, 32'h0500_0000);
    bus_write(10'h018, 4'hF, 32'hDEAD_BEEF);
    bus_read(10'h018, 32'h0);
  endtask

  task automatic test_slot_wrap();
    do_reset();
    spi(8'h23);
    n_cmp++; if (SLOT_SEL !== 2'd3) begin n_err++; $display("FAIL wrap_start: got %0d want 3", SLOT_SEL); end
    spi(8'h30);
    n_cmp++; if ({SLOT_SEL, SLOT_CHG} !== {2'd0, 1'b1}) begin n_err++; $display("FAIL wrap_inc: got %0d/%0d want 0/1", SLOT_SEL, SLOT_CHG); end
    spi(8'h31);
    n_cmp++; if (SLOT_SEL !== 2'd3) begin n_err++; $display("FAIL wrap_dec: got %0d want 3", SLOT_SEL); end
    spi(8'h23);
    n_cmp++; if ({SLOT_SEL, SLOT_CHG} !== {2'd3, 1'b1}) begin n_err++; $display("FAIL same_load: got %0d/%0d want 3/1", SLOT_SEL, SLOT_CHG); end
    spi(8'h1F);
    n_cmp++; if ({SLOT_SEL, SLOT_CHG} !== {2'd3, 1'b0}) begin n_err++; $display("FAIL noop: got %0d/%0d want 3/0", SLOT_SEL, SLOT_CHG); end
    bus_read(10'h004, spi_hist);
  endtask

  task automatic test_collision();
    do_reset();
    WRADDR = {4'h3, 10'h000, 2'b00}; BYTEEN = 4'h1; WDATA = 32'h5; WREN = 1'b1;
    SPI_GET_DATA = 8'h62; SPI_DATA_VALID = 1'b1; spi_hist = {spi_hist[23:0], 8'h62};
    tick(); WREN = 1'b0; SPI_DATA_VALID = 1'b0;
    n_cmp++; if ({COMMAND, LOOP} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL ctrl_collision: got %0d/%0d want 1/1", COMMAND, LOOP); end
    bus_read(10'h004, spi_hist);
    spi(8'h23);
    WRADDR = {4'h3, 10'h003, 2'b00}; BYTEEN = 4'h1; WDATA = 32'h1; WREN = 1'b1;
    SPI_GET_DATA = 8'h30; SPI_DATA_VALID = 1'b1; spi_hist = {spi_hist[23:0], 8'h30};
    tick(); WREN = 1'b0; SPI_DATA_VALID = 1'b0;
    n_cmp++; if ({SLOT_SEL, SLOT_CHG} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL slot_collision: got %0d/%0d want 1/1", SLOT_SEL, SLOT_CHG); end
    WRADDR = {4'h3, 10'h001, 2'b00}; BYTEEN = 4'b0010; WDATA = 32'h0000_4000; WREN = 1'b1;
    SPI_GET_DATA = 8'hC5; SPI_DATA_VALID = 1'b1; spi_hist = {spi_hist[23:0], 8'hC5};
    tick(); WREN = 1'b0; SPI_DATA_VALID = 1'b0;
    bus_read(10'h001, 32'h0000_4000);
    WRADDR = {4'h3, 10'h001, 2'b00}; BYTEEN = 4'b0010; WDATA = 32'h0000_2200; WREN = 1'b1;
    SPI_GET_DATA = 8'h81; SPI_DATA_VALID = 1'b1; spi_hist = {spi_hist[23:0], 8'h81};
    tick(); WREN = 1'b0; SPI_DATA_VALID = 1'b0;
    bus_read(10'h001, 32'h0000_2204);
    WRADDR = {4'h3, 10'h002, 2'b00}; BYTEEN = 4'h1; WDATA = 32'h21; WREN = 1'b1;
    SPI_GET_DATA = 8'h5F; SPI_DATA_VALID = 1'b1; spi_hist = {spi_hist[23:0], 8'h5F};
    tick(); WREN = 1'b0; SPI_DATA_VALID = 1'b0;
    n_cmp++; if ({FIL_PARAM_L, FIL_PARAM_R} !== 8'h12) begin n_err++; $display("FAIL fil_collision: got %h/%h want 1/2", FIL_PARAM_L, FIL_PARAM_R); end
    bus_read(10'h004, spi_hist);
  endtask

  task automatic test_volume_filter();
    do_reset();
    bus_write(10'h001, 4'h3, 32'h0000_5566);
    bus_write(10'h001, 4'b0010, 32'h0000_AB11);
`ifndef SND_VOL_RAMP_EN
    n_cmp++; if ({VOLUME_L, VOLUME_R} !== 16'hAB66) begin n_err++; $display("FAIL vol_direct: got %h/%h want ab/66", VOLUME_L, VOLUME_R); end
    bus_read(10'h005, 32'h0000_AB66);
`endif
    bus_read(10'h001, 32'h0000_AB66);
    bus_read(10'h1FF, 32'h0);
    spi(8'hBF);
    bus_write(10'h005, 4'hF, 32'hFFFF_FFFF);
    bus_write(10'h1FF, 4'hF, 32'hFFFF_FFFF);
    bus_write(10'h004, 4'hF, 32'hFFFF_FFFF);
    bus_read(10'h001, 32'h0000_ABFC);
    bus_read(10'h004, spi_hist);
    bus_write(10'h002, 4'h1, 32'h0000_00A5);
    n_cmp++; if ({FIL_PARAM_L, FIL_PARAM_R} !== 8'h5A) begin n_err++; $display("FIL_L/R FAIL fil_bus: got %h/%h want 5/a", FIL_PARAM_L, FIL_PARAM_R); end
    spi(8'h53);
    n_cmp++; if ({FIL_PARAM_L, FIL_PARAM_R} !== 8'h53) begin n_err++; $display("FAIL fil_spi: got %h/%h want 5/3", FIL_PARAM_L, FIL_PARAM_R); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_write(10'h000, 4'h1, 32'h0000_0006);
    bus_read(10'h000, 32'h6);
    bus_read(10'h003, 32'h0);
    bus_read(10'h000, 32'h6);
    RDADDR = {4'h2, 10'h003, 2'b00}; RDEN = 1'b1; exp_q.push_back(last_rd);
    tick(); RDEN = 1'b0;
    tick();
    n_cmp++; if (RDATA !== 32'h6) begin n_err++; $display("FAIL rdata_hold: got %08h want 00000006", RDATA); end
  endtask

`ifdef SND_VOL_RAMP_EN
  task automatic test_ramp();
    int cnt; int since; bit first; logic [7:0] prev;
    do_reset();
    spi(8'hFF); spi(8'hBF);
    prev = VOLUME_L; cnt = 0; since = 0; first = 1'b1;
    while (VOLUME_L !== 8'hFC && cnt < 252 * 4 + 16) begin
      tick(); cnt++; since++;
      if (VOLUME_L !== prev) begin
        n_cmp++;
        if (VOLUME_L !== prev + 8'd1 || (!first && since != 4)) begin
          n_err++; $display("FAIL ramp_up_step: got %h after %0d cycles want %h after 4", VOLUME_L, since, prev + 8'd1);
        end
        first = 1'b0; since = 0; prev = VOLUME_L;
      end
    end
    n_cmp++; if (VOLUME_L !== 8'hFC || cnt < 251 * 4 || cnt > 252 * 4) begin
      n_err++; $display("FAIL ramp_up_time: got %h after %0d cycles want fc after 1004..1008", VOLUME_L, cnt);
    end
    repeat (8) tick();
    n_cmp++; if ({VOLUME_L, VOLUME_R} !== 16'hFCFC) begin n_err++; $display("FAIL ramp_hold: got %h/%h want fc/fc", VOLUME_L, VOLUME_R); end
    do_reset();
    spi(8'hFF);
    cnt = 0;
    while (VOLUME_L !== 8'd100 && cnt < 100 * 4 + 8) begin tick(); cnt++; end
    n_cmp++; if (VOLUME_L !== 8'd100) begin n_err++; $display("FAIL ramp_mid: got %0d want 100", VOLUME_L); end
    bus_write(10'h001, 4'h3, 32'h0);
    n_cmp++; if (VOLUME_L !== 8'd100 && VOLUME_L !== 8'd101) begin n_err++; $display("FAIL ramp_turn: got %0d want 100 or 101", VOLUME_L); end
    prev = VOLUME_L; cnt = 0;
    while (VOLUME_L !== 8'h00 && cnt < 102 * 4 + 8) begin
      tick(); cnt++;
      if (VOLUME_L !== prev) begin
        n_cmp++; if (VOLUME_L !== prev - 8'd1) begin n_err++; $display("FAIL ramp_down_step: got %0d want %0d", VOLUME_L, prev - 8'd1); end
        prev = VOLUME_L;
      end
    end
    repeat (8) tick();
    n_cmp++; if (VOLUME_L !== 8'h00) begin n_err++; $display("FAIL ramp_down_end: got %0d want 0", VOLUME_L); end
  endtask
`endif

  task automatic test_reset_midramp();
    do_reset();
    bus_write(10'h012, 4'hF, 32'h0ABC_DEF0);
    bus_write(10'h013, 4'hF, 32'h0000_0800);
    spi(8'h21); spi(8'h63); spi(8'h47); spi(8'hFF); spi(8'hBF);
    bus_write(10'h000, 4'h1, 32'h7);
    repeat (40) tick();
    bus_read(10'h012, 32'h0ABC_DEF0);
    n_cmp++; if (SNDADDR !== 29'h0ABC_DEF0) begin n_err++; $display("FAIL pre_reset_addr: got %h want abcdef0", SNDADDR); end
`ifdef SND_VOL_RAMP_EN
    n_cmp++; if (VOLUME_L === 8'h00 || VOLUME_L === 8'hFC) begin n_err++; $display("FAIL pre_reset_ramp: got %h want mid-ramp", VOLUME_L); end
`else
    n_cmp++; if (VOLUME_L !== 8'hFC) begin n_err++; $display("FAIL pre_reset_vol: got %h want fc", VOLUME_L); end
`endif
    ARST = 1'b1; tick(); ARST = 1'b0;
    spi_hist = 32'h0; last_rd = 32'h0;
    n_cmp++;
    if ({COMMAND, LOOP, SNDADDR, DATASIZE, SLOT_SEL, SLOT_CHG, VOLUME_L, VOLUME_R,
         FIL_PARAM_L, FIL_PARAM_R, RDATA} !== 120'h0) begin
      n_err++; $display("FAIL midramp_reset: got cmd=%0d loop=%0d addr=%h slot=%0d chg=%0d vol=%h/%h fil=%h/%h rdata=%h want all 0",
                        COMMAND, LOOP, SNDADDR, SLOT_SEL, SLOT_CHG, VOLUME_L, VOLUME_R, FIL_PARAM_L, FIL_PARAM_R, RDATA);
    end
    repeat (20) tick();
    n_cmp++; if ({VOLUME_L, VOLUME_R, SLOT_CHG} !== 17'h0) begin n_err++; $display("FAIL post_reset_idle: got %h/%h chg=%0d want 0", VOLUME_L, VOLUME_R, SLOT_CHG); end
    bus_read(10'h001, 32'h0);
  endtask

  initial begin
    test_reset();
    test_slot_select();
    test_slot_wrap();
    test_collision();
    test_volume_filter();
    test_back_to_back();
`ifdef SND_VOL_RAMP_EN
    test_ramp();
`endif
    test_reset_midramp();
    repeat (3) tick();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snd_regctrl_mc.md
# snd_regctrl_mc

Multi-slot register controller for the sound IP. It sits between the register bus / SPI command receiver and the sound playback engine. It holds NSLOT independent (address, size) sample slots, a selected-slot pointer, per-channel volume and filter settings, and the play command. Volume changes from either source can optionally reach the outputs through a rate-limited ramp to avoid zipper noise.

## Interface
- NSLOT, 4: number of sample slots; power of two, 2..16; SW = log2(NSLOT).
- RAMP_DIV, 1024: ACLK cycles per volume ramp step; ≥2.

Reset ARST, synchronous, active-high; clock ACLK.

- ACLK  in  1  clock
- ARST  in  1  synchronous active-high reset
- WRADDR  in  16  write address
- BYTEEN  in  4  write byte enables
- WREN  in  1  write strobe
- WDATA  in  32  write data
- RDADDR  in  16  read address
- RDEN  in  1  read strobe
- RDATA  out  32  read data, registered
- SPI_GET_DATA  in  8  received SPI command byte
- SPI_DATA_VALID  in  1  one-cycle strobe qualifying SPI_GET_DATA
- COMMAND  out  2  play command
- LOOP  out  1  loop enable
- SNDADDR  out  29  start address of the selected slot
- DATASIZE  out  29  size of the selected slot
- SLOT_SEL  out  SW  selected slot index
- SLOT_CHG  out  1  one-cycle pulse whenever SLOT_SEL is loaded
- VOLUME_L / VOLUME_R  out  8 each  effective volume
- FIL_PARAM_L / FIL_PARAM_R  out  4 each  filter selection

## Operation
- A register hit requires WRADDR[15:12]==4'h3 with WREN, or RDADDR[15:12]==4'h3 with RDEN. The word index is addr[11:2].
- 0x000 CTRL: [1:0] COMMAND, [2] LOOP. Written when BYTEEN[0] is set.
- 0x001 VOLUME: [15:8] L target, [7:0] R target. Each byte is written under its own enable.
- 0x002 FILTER: [3:0] L, [7:4] R. Written when BYTEEN[0] is set.
- 0x003 SLOT: [SW-1:0] slot select. Written when BYTEEN[0] is set.
- 0x004 SPISTAT (read-only): last four SPI bytes, newest in [7:0].
- 0x005 VOLNOW (read-only): {16'b0, VOLUME_L, VOLUME_R}.
- 0x010+2k ADDR[k] and 0x011+2k SIZE[k], for k < NSLOT: 29 bits each, per-byte enables. Byte 3 writes only WDATA[28:24].
- Writes to read-only or unmapped indices are ignored. Reads of unmapped indices return 0. Unused bits read 0.
- SPI decode happens on every SPI_DATA_VALID. Every byte, including no-ops, shifts into SPISTAT.
  - 000xxxxx: no-op.
  - 001_0_dddd: slot ← d[SW-1:0].
  - 001_1_xxx0: slot ← slot+1, wrapping NSLOT-1→0.
  - 001_1_xxx1: slot ← slot−1, wrapping 0→NSLOT-1.
  - 010_c_ffff: c=0 loads FIL_L ← f; c=1 loads FIL_R ← f.
  - 011xxxcc: COMMAND ← cc.
  - 10vvvvvv: R target ← {v,2'b00}.
  - 11vvvvvv: L target ← {v,2'b00}.
- When a bus write and an SPI byte hit the same field in the same cycle, the bus write wins. Other fields touched by the SPI byte still update.
- SNDADDR, DATASIZE and SLOT_SEL are combinational from registered state: ADDR[SLOT_SEL], SIZE[SLOT_SEL], and the slot register.
- SLOT_CHG pulses for one cycle, concurrent with the new SLOT_SEL value. It pulses on every load, even if the value is unchanged. A slot change does not modify COMMAND.

## Timing
- Reset values: every register 0. That means all slots, targets, filters, COMMAND, LOOP, SLOT_SEL, SPISTAT and RDATA are 0, and SLOT_CHG is 0. The ramp divider and current volume are also 0.
- Bus writes and SPI bytes take effect on outputs on the cycle after the strobe edge.
- Read latency is 1 cycle. RDATA is loaded only on a register-hit read and otherwise holds its value.
- Ramp: a free-running divider counts 0..RAMP_DIV−1. At terminal count, each channel's current volume moves ±1 toward its target, or stays if equal.
- If the target changes mid-ramp, the ramp continues from the current value toward the new target.
- A full 0→0xFC ramp takes 252 steps, i.e. 252·RAMP_DIV cycles.
- ARST asserted mid-ramp clears current volume, targets and the divider on the next edge.

## Configuration
- SND_VOL_RAMP_EN defined: VOLUME_L/R are the ramped current values, as described above.
- SND_VOL_RAMP_EN undefined: VOLUME_L/R equal the target registers directly, one cycle after the write. No divider is built, and VOLNOW reads the targets.

## Test plan
- Write ADDR[2]=0x1234_5678 and SIZE[2]=0x0000_1000, then SPI byte 0x22 → SLOT_SEL=2, SLOT_CHG pulses once, SNDADDR=0x1234_5678, DATASIZE=0x1000. Reading 0x014 returns 0x1234_5678.
- From SLOT_SEL=3 (NSLOT=4), SPI 0x30 → SLOT_SEL=0. Then SPI 0x31 → SLOT_SEL=3.
- Bus write CTRL=0x5 in the same cycle as SPI byte 0x62 → COMMAND=1, LOOP=1, and SPISTAT[7:0]=0x62.
- SPI 0xFF, then 0xBF, with the ramp enabled and RAMP_DIV=4 → VOLUME_L reaches 0xFC after 252·4 cycles, stepping by 1 every 4 cycles. Writing VOLUME=0x0000 at step 100 makes it ramp back down to 0.
- VOLUME write with BYTEEN=4'b0010 and WDATA=0x0000_AB11 → L target=0xAB, R unchanged. A read of 0x1FF returns 0.
- Assert ARST mid-ramp with slot 1 selected → every output reads 0 the next cycle, and SLOT_CHG stays low.
